// File: rtl/cipher_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cipher_sequencer_pkg
// Shared types and constants for the iterative AES-128 sequencer.
//   block_t     : 128-bit AES state / key block
//   round_t     : 4-bit round number (0 = none issued yet, 1..NR)
//   seq_state_t : sequencer FSM encoding
// ---------------------------------------------------------------------------
package cipher_sequencer_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned BLOCK_W   = 128;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [3:0]         round_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // True when the round just completed is the final one.
    function automatic logic is_final_round(input round_t rnd, input int unsigned nr);
        is_final_round = (rnd == round_t'(nr));
    endfunction

endpackage

// File: rtl/cipher_sequencer.sv
// ---------------------------------------------------------------------------
// cipher_sequencer
// Iterative AES-128 encryption controller. Performs the initial AddRoundKey,
// then issues rounds 1..NR to an external shared round datapath, looping the
// returned state and round key back each time, and finally hands out the
// ciphertext.
//
// Ports
//   clock, reset        : clock and synchronous active-high reset
//   i_valid / o_ready   : request handshake (i_plaintext, i_key)
//   o_valid / i_ready   : result handshake (o_ciphertext)
//   o_error             : one-cycle pulse when the datapath does not answer
//   o_dp_tx_en          : one-cycle round issue pulse to the datapath
//   o_dp_round          : round number being issued (1..NR)
//   o_dp_state          : state handed to the datapath
//   o_dp_round_key      : previous round key handed to the datapath
//   i_dp_tx_en          : datapath result pulse (only honoured in WAIT)
//   i_dp_state          : datapath output state
//   i_dp_round_key      : round key produced by the datapath
//
// o_dp_state, o_dp_round_key and o_dp_round double as the working state,
// key and round registers: they only change when leaving IDLE or WAIT, so
// they are naturally stable for the whole time a round is outstanding.
// ---------------------------------------------------------------------------
module cipher_sequencer
    import cipher_sequencer_pkg::*;
#(
    parameter int unsigned NR         = NR_AES128,
    parameter int unsigned DP_TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  block_t       i_plaintext,
    input  block_t       i_key,
    output logic         o_valid,
    input  logic         i_ready,
    output block_t       o_ciphertext,
    output logic         o_error,
    output logic         o_dp_tx_en,
    output round_t       o_dp_round,
    output block_t       o_dp_state,
    output block_t       o_dp_round_key,
    input  logic         i_dp_tx_en,
    input  block_t       i_dp_state,
    input  block_t       i_dp_round_key
);

    localparam int unsigned TO_W = (DP_TIMEOUT > 2) ? $clog2(DP_TIMEOUT) : 2;

    seq_state_t          fsm_r;
    logic [TO_W-1:0]     timeout_cnt_r;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_r          <= IDLE;
            timeout_cnt_r  <= '0;
            o_ready        <= 1'b1;
            o_valid        <= 1'b0;
            o_error        <= 1'b0;
            o_dp_tx_en     <= 1'b0;
            o_dp_round     <= 4'd0;
            o_ciphertext   <= 128'd0;
            o_dp_state     <= 128'd0;
            o_dp_round_key <= 128'd0;
        end else begin
            // Pulse outputs default low; the branches below raise them.
            o_dp_tx_en <= 1'b0;
            o_error    <= 1'b0;

            case (fsm_r)
                IDLE: begin
                    if (i_valid) begin
                        // Initial AddRoundKey is done here, not in the datapath.
                        o_dp_state     <= i_plaintext ^ i_key;
                        o_dp_round_key <= i_key;
                        o_dp_round     <= 4'd1;
                        o_dp_tx_en     <= 1'b1;
                        o_ready        <= 1'b0;
                        fsm_r          <= ISSUE;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end

                ISSUE: begin
                    timeout_cnt_r <= '0;
                    fsm_r         <= WAIT;
                end

                WAIT: begin
                    if (i_dp_tx_en) begin
                        o_dp_state     <= i_dp_state;
                        o_dp_round_key <= i_dp_round_key;
                        if (is_final_round(o_dp_round, NR)) begin
                            o_valid      <= 1'b1;
                            o_ciphertext <= i_dp_state;
                            fsm_r        <= DONE;
                        end else begin
                            o_dp_round <= o_dp_round + 4'd1;
                            o_dp_tx_en <= 1'b1;
                            fsm_r      <= ISSUE;
                        end
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
                        // Abort on the edge where the counter reaches DP_TIMEOUT-1.
                        if (timeout_cnt_r == TO_W'(DP_TIMEOUT - 2)) begin
                            o_error <= 1'b1;
                            o_ready <= 1'b1;
                            fsm_r   <= IDLE;
                        end else begin
                            fsm_r <= WAIT;
                        end
                    end
                end

                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        fsm_r   <= IDLE;
                    end else begin
                        fsm_r <= DONE;
                    end
                end

                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    fsm_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
